// File: rtl/ring_rx_checker_if.sv
// Bus between a ring-pattern source and the ring receive checker.
// The master drives the sample and control strobes; the slave (checker)
// returns the decoded phase and health flags.
interface ring_rx_checker_if #(
    parameter int WIDTH = 4,
    parameter int ERR_W = 8
);
    localparam int IDX_W = $clog2(WIDTH);

    logic             en;
    logic [WIDTH-1:0] ring_in;
    logic             clr_err;
    logic [IDX_W-1:0] idx;
    logic             idx_valid;
    logic             locked;
    logic             err;
    logic             bad;
    logic [ERR_W-1:0] err_cnt;

    modport master (
        output en, ring_in, clr_err,
        input  idx, idx_valid, locked, err, bad, err_cnt
    );

    modport slave (
        input  en, ring_in, clr_err,
        output idx, idx_valid, locked, err, bad, err_cnt
    );
endinterface

// File: rtl/ring_rx_checker.sv
// Receive-side checker for the one-hot ring counter link.
// Acquires the rotation, locks after LOCK_CNT correct rotations, then reports
// the hot-bit index each enabled cycle and flags rotation / one-hot faults.
//
// state  | meaning
// SEEK   | waiting for a one-hot sample to seed the expected pattern
// VERIFY | counting consecutive correct rotations towards lock
// LOCKED | tracking; idx updated per sample, mismatches raise err
module ring_rx_checker #(
    parameter int WIDTH    = 4,
    parameter int LOCK_CNT = 2,
    parameter int ERR_W    = 8
) (
    input  logic               clk,
    input  logic               pset,
    ring_rx_checker_if.slave   bus
);
    localparam int IDX_W = $clog2(WIDTH);
    localparam int MC_W  = $clog2(LOCK_CNT + 1);

    typedef enum logic [1:0] {
        SEEK   = 2'd0,
        VERIFY = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   exp_q;
    logic [MC_W-1:0]    match_cnt_q;
    logic [IDX_W-1:0]   idx_q;
    logic               idx_valid_q;
    logic               locked_q;
    logic               err_q;
    logic               bad_q;
    logic [ERR_W-1:0]   err_cnt_q;
    logic [ERR_W-1:0]   err_cnt_d;

    logic               onehot_ok;
    logic               exp_match;
    logic               err_fire;
    logic [WIDTH-1:0]   rot_in;
    logic [IDX_W-1:0]   hot_idx;
    logic [IDX_W:0]     ones;

    // Sample decode: popcount, hot position and the rotated successor.
    always_comb begin
        ones    = '0;
        hot_idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (bus.ring_in[i]) begin
                ones    = ones + 1'b1;
                hot_idx = IDX_W'(i);
            end
        end
        onehot_ok = (ones == (IDX_W+1)'(1));
        rot_in    = {bus.ring_in[0], bus.ring_in[WIDTH-1:1]};
        exp_match = (bus.ring_in == exp_q);
        err_fire  = bus.en && (state_q == LOCKED) && !exp_match;
    end

    // Error counter next value: clear wins over a simultaneous error.
    always_comb begin
        err_cnt_d = err_cnt_q;
        if (bus.clr_err) begin
            err_cnt_d = '0;
        end else if (err_fire && (err_cnt_q != {ERR_W{1'b1}})) begin
            err_cnt_d = err_cnt_q + 1'b1;
        end
    end

    // Acquisition FSM with registered outputs; en=0 freezes tracking state.
    always_ff @(posedge clk or posedge pset) begin
        if (pset) begin
            state_q     <= SEEK;
            exp_q       <= '0;
            match_cnt_q <= '0;
            idx_q       <= '0;
            idx_valid_q <= 1'b0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            bad_q       <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            err_cnt_q   <= err_cnt_d;
            idx_valid_q <= 1'b0;
            err_q       <= 1'b0;
            bad_q       <= bus.en & ~onehot_ok;
            if (bus.en) begin
                case (state_q)
                    SEEK: begin
                        if (onehot_ok) begin
                            exp_q       <= rot_in;
                            match_cnt_q <= '0;
                            state_q     <= VERIFY;
                        end
                    end
                    VERIFY: begin
                        if (exp_match) begin
                            exp_q       <= rot_in;
                            match_cnt_q <= match_cnt_q + 1'b1;
                            if ((match_cnt_q + 1'b1) == MC_W'(LOCK_CNT)) begin
                                state_q  <= LOCKED;
                                locked_q <= 1'b1;
                            end
                        end else begin
                            match_cnt_q <= '0;
                            state_q     <= SEEK;
                        end
                    end
                    LOCKED: begin
                        if (exp_match) begin
                            exp_q       <= rot_in;
                            idx_q       <= hot_idx;
                            idx_valid_q <= 1'b1;
                        end else begin
                            err_q       <= 1'b1;
                            match_cnt_q <= '0;
                            state_q     <= SEEK;
                            locked_q    <= 1'b0;
                        end
                    end
                    default: begin
                        state_q  <= SEEK;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.idx       = idx_q;
    assign bus.idx_valid = idx_valid_q;
    assign bus.locked    = locked_q;
    assign bus.err       = err_q;
    assign bus.bad       = bad_q;
    assign bus.err_cnt   = err_cnt_q;
endmodule

// File: doc/ring_rx_checker.md
Name: ring_rx_checker

Overview:
- Receiving end of the team's one-hot ring counter link. Samples a WIDTH-bit ring pattern each enabled cycle and checks that it rotates legally.
- Locks after a run of correct rotations, then outputs the binary index of the hot bit.
- Flags and counts rotation and one-hot violations, and re-acquires automatically.
- Sits downstream of the ring counter, as a phase decoder and health monitor.

Parameters:
- WIDTH, 4, ring width in bits (>=2).
- LOCK_CNT, 2, consecutive correct rotations required to enter LOCKED (>=1).
- ERR_W, 8, width of the saturating error counter.
- IDX_W, $clog2(WIDTH), width of the index output (derived; not overridden).

Ports:
- clk  in  1  rising-edge clock.
- pset  in  1  asynchronous, active-high reset.
- en  in  1  sample enable; ring_in is evaluated only when en=1.
- ring_in  in  WIDTH  ring pattern from the ring counter.
- clr_err  in  1  synchronous clear of err_cnt.
- idx  out  IDX_W  binary position of the hot bit of the last accepted sample.
- idx_valid  out  1  1-cycle pulse: idx was updated from a sample accepted in LOCKED.
- locked  out  1  1 while the FSM is in LOCKED.
- err  out  1  1-cycle pulse: rotation mismatch detected while LOCKED.
- bad  out  1  1-cycle pulse: enabled sample was not one-hot (zero bits or more than one bit set).
- err_cnt  out  ERR_W  saturating count of err pulses.

Behaviour:
- Legal rotation: next = rotr(cur), i.e. bit i takes bit i+1 and bit WIDTH-1 takes bit 0. For WIDTH=4: 1000->0100->0010->0001->1000.
- Reset (pset=1, async): FSM=SEEK; exp=0; match_cnt=0; idx=0; idx_valid=0; locked=0; err=0; bad=0; err_cnt=0. A reset mid-lock drops locked immediately, without waiting for a clock edge.
- All outputs are registered. Each output reflects the sample taken on the previous rising edge with en=1, so latency is 1 cycle.
- en=0: state, exp, match_cnt, idx and err_cnt are held (clr_err still acts). idx_valid, err and bad are driven 0.
- onehot_ok = popcount(ring_in)==1. bad <= en & ~onehot_ok in every state.
- FSM states: SEEK, VERIFY, LOCKED.
  - SEEK, onehot_ok: exp <= rotr(ring_in); match_cnt <= 0; go to VERIFY.
  - SEEK, otherwise: stay in SEEK.
  - VERIFY, ring_in==exp: exp <= rotr(ring_in); match_cnt++. If match_cnt+1==LOCK_CNT, go to LOCKED.
  - VERIFY, mismatch: go to SEEK; match_cnt <= 0; no err pulse. If the mismatching sample is itself one-hot, it is not re-used for capture; SEEK captures on its next sample.
  - LOCKED, ring_in==exp: exp <= rotr(ring_in); idx <= position of the hot bit; idx_valid <= 1.
  - LOCKED, mismatch (including non-one-hot): err <= 1; idx held; go to SEEK.
- Position encoding: idx = i where ring_in[i]=1. For 1000 (WIDTH=4), idx=3.
- idx is updated only on samples accepted in LOCKED; it is never updated in SEEK or VERIFY.
- Wrap-around: the transition from bit 0 back to bit WIDTH-1 is legal, with no special casing.
- err_cnt increments on each err and saturates at 2^ERR_W-1 (no wrap).
- clr_err takes priority. If clr_err and err occur in the same cycle, err_cnt <= 0; the err pulse is still emitted.
- An all-zeros or multi-hot sample in SEEK raises only bad; state stays SEEK.
- A sample with ring_in==exp is accepted regardless of popcount; exp is always one-hot by construction.

Test Plan:
- Reset, then en=1 with ring_in 1000, 0100, 0010, 0001, 1000 on consecutive cycles:
  - locked=1 the cycle after sample 3 (0010).
  - Sample 4 gives idx=0, idx_valid=1; sample 5 gives idx=3, idx_valid=1.
  - err and bad stay 0 throughout.
- Locked on 0100, then inject 0001 instead of 0010:
  - Next cycle: err=1 for 1 cycle, err_cnt=1, locked=0.
  - Resume a legal sequence: relock after LOCK_CNT more correct rotations.
- Inputs 0000 and then 1100 in SEEK:
  - bad=1 each following cycle; locked=0; err=0; err_cnt=0.
- Locked, then hold en=0 for 3 cycles while ring_in changes arbitrarily, then resume with the correct next pattern:
  - No err, idx_valid=0 during the hold; lock is retained.
- ERR_W=2: force 5 lock-and-break cycles:
  - err_cnt reads 1, 2, 3, 3, 3.
  - Then assert clr_err in the same cycle as an err: err_cnt=0 and err=1.
- Locked mid-sequence, then assert pset asynchronously between edges:
  - locked, idx and err_cnt go to 0 immediately.
  - After release, the first one-hot sample moves the FSM to VERIFY, with no err.
